// File: rtl/rx_da_filter.sv
// Receive destination-address filter: compares a streamed 48-bit DA against the
// station address and issues a single accept/reject pulse per frame.
module rx_da_filter #(
    parameter int unsigned DW    = 4,
    parameter int unsigned BEATS = 48 / DW,
    parameter int unsigned CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          I_en_ck,
    input  logic [DW-1:0] I_da_hf,
    input  logic [47:0]   I_mac_addr,
    input  logic          I_promisc,
    input  logic          I_bc_en,
    input  logic          I_mc_en,
    output logic          O_da_ok,
    output logic          O_da_err,
    output logic [1:0]    O_da_type,
    output logic          O_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CMP  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0]    TYPE_UC   = 2'b00;
    localparam logic [1:0]    TYPE_MC   = 2'b01;
    localparam logic [1:0]    TYPE_BC   = 2'b10;
    localparam logic [1:0]    TYPE_TRUN = 2'b11;
    localparam logic [DW-1:0] ALL_ONES  = {DW{1'b1}};
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    // Reorders the address so beat i sits at bits [i*DW +: DW] (octet 0 lowest).
    function automatic logic [47:0] wire_order(input logic [47:0] addr);
        logic [47:0] v;
        v = 48'h0;
        for (int k = 0; k < 6; k++) begin
            v[8*k +: 8] = addr[47-8*k -: 8];
        end
        return v;
    endfunction

    state_t        state_r, state_next_s;
    logic [CW-1:0] cnt_r, cnt_next_s;
    logic          uc_r, uc_next_s, bc_r, bc_next_s, ig_r, ig_next_s;
    logic          promisc_r, promisc_next_s, bc_en_r, bc_en_next_s, mc_en_r, mc_en_next_s;
    logic [47:0]   stream_r, stream_next_s;
    logic          ok_r, ok_next_s, err_r, err_next_s, busy_r, busy_next_s;
    logic [1:0]    type_r, type_next_s;
    logic [47:0]   wire_mac_s, shifted_s;
    logic [DW-1:0] exp_s;
    logic          uc_fin_s, bc_fin_s, accept_s;

    // Next-state, match accumulation and decision logic.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        uc_next_s      = uc_r;
        bc_next_s      = bc_r;
        ig_next_s      = ig_r;
        promisc_next_s = promisc_r;
        bc_en_next_s   = bc_en_r;
        mc_en_next_s   = mc_en_r;
        stream_next_s  = stream_r;
        ok_next_s      = 1'b0;
        err_next_s     = 1'b0;
        type_next_s    = type_r;
        accept_s       = 1'b0;
        wire_mac_s     = wire_order(I_mac_addr);
        shifted_s      = stream_r >> (32'(cnt_r) * DW);
        exp_s          = shifted_s[DW-1:0];
        uc_fin_s       = uc_r & (I_da_hf == exp_s);
        bc_fin_s       = bc_r & (I_da_hf == ALL_ONES);
        case (state_r)
            ST_IDLE: begin
                if (I_en_ck) begin
                    state_next_s   = ST_CMP;
                    cnt_next_s     = CW'(1);
                    uc_next_s      = (I_da_hf == wire_mac_s[DW-1:0]);
                    bc_next_s      = (I_da_hf == ALL_ONES);
                    ig_next_s      = I_da_hf[0];
                    promisc_next_s = I_promisc;
                    bc_en_next_s   = I_bc_en;
                    mc_en_next_s   = I_mc_en;
                    stream_next_s  = wire_mac_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CMP: begin
                if (I_en_ck) begin
                    uc_next_s  = uc_fin_s;
                    bc_next_s  = bc_fin_s;
                    cnt_next_s = cnt_r + CW'(1);
                    if (cnt_r == LAST_BEAT) begin
                        // Broadcast outranks multicast, which outranks unicast.
                        if (bc_fin_s) begin
                            type_next_s = TYPE_BC;
                            accept_s    = bc_en_r | promisc_r;
                        end else if (ig_r) begin
                            type_next_s = TYPE_MC;
                            accept_s    = mc_en_r | promisc_r;
                        end else begin
                            type_next_s = TYPE_UC;
                            accept_s    = uc_fin_s | promisc_r;
                        end
                        ok_next_s    = accept_s;
                        err_next_s   = ~accept_s;
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_CMP;
                    end
                end else begin
                    err_next_s   = 1'b1;
                    type_next_s  = TYPE_TRUN;
                    state_next_s = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (I_en_ck) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        busy_next_s = (state_next_s == ST_CMP);
    end

    // State, frame context and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            uc_r      <= 1'b0;
            bc_r      <= 1'b0;
            ig_r      <= 1'b0;
            promisc_r <= 1'b0;
            bc_en_r   <= 1'b0;
            mc_en_r   <= 1'b0;
            stream_r  <= 48'h0;
            ok_r      <= 1'b0;
            err_r     <= 1'b0;
            type_r    <= 2'b00;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            uc_r      <= uc_next_s;
            bc_r      <= bc_next_s;
            ig_r      <= ig_next_s;
            promisc_r <= promisc_next_s;
            bc_en_r   <= bc_en_next_s;
            mc_en_r   <= mc_en_next_s;
            stream_r  <= stream_next_s;
            ok_r      <= ok_next_s;
            err_r     <= err_next_s;
            type_r    <= type_next_s;
            busy_r    <= busy_next_s;
        end
    end

    assign O_da_ok   = ok_r;
    assign O_da_err  = err_r;
    assign O_da_type = type_r;
    assign O_busy    = busy_r;

endmodule

// File: tb/tb_rx_da_filter.sv
// Directed bench for rx_da_filter: nibble-mode table of frames plus byte-mode
// overlong/back-to-back and mid-frame reset sequences.
module tb_rx_da_filter;

    logic        clk, rst;
    logic        en4, promisc4, bc_en4, mc_en4, ok4, err4, busy4;
    logic [3:0]  da4;
    logic [47:0] mac4;
    logic [1:0]  type4;
    logic        en8, promisc8, bc_en8, mc_en8, ok8, err8, busy8;
    logic [7:0]  da8;
    logic [47:0] mac8;
    logic [1:0]  type8;

    int n_pass = 0;
    int n_total = 0;

    rx_da_filter #(.DW(4)) dut4 (
        .clk(clk), .rst(rst), .I_en_ck(en4), .I_da_hf(da4), .I_mac_addr(mac4),
        .I_promisc(promisc4), .I_bc_en(bc_en4), .I_mc_en(mc_en4),
        .O_da_ok(ok4), .O_da_err(err4), .O_da_type(type4), .O_busy(busy4)
    );

    rx_da_filter #(.DW(8)) dut8 (
        .clk(clk), .rst(rst), .I_en_ck(en8), .I_da_hf(da8), .I_mac_addr(mac8),
        .I_promisc(promisc8), .I_bc_en(bc_en8), .I_mc_en(mc_en8),
        .O_da_ok(ok8), .O_da_err(err8), .O_da_type(type8), .O_busy(busy8)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [47:0] da;
        logic [47:0] mac;
        logic        promisc;
        logic        bc_en;
        logic        mc_en;
        int          nbeats;
        logic        ok;
        logic        err;
        logic [1:0]  typ;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Nibble i of a DA in transmission order: low nibble of each octet first.
    function automatic logic [3:0] nib(input logic [47:0] da, input int i);
        logic [7:0] oct;
        oct = da[47-8*(i/2) -: 8];
        return (i % 2 == 1) ? oct[7:4] : oct[3:0];
    endfunction

    task automatic run_vec(input vec_t v);
        mac4     = v.mac;
        promisc4 = v.promisc;
        bc_en4   = v.bc_en;
        mc_en4   = v.mc_en;
        for (int i = 0; i < v.nbeats; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk({v.name, "_busy"}, {3'b0, busy4}, 4'h1);
            end
            en4 = 1'b1;
            da4 = nib(v.da, i);
        end
        @(negedge clk);
        if (v.nbeats == 12) begin
            chk({v.name, "_ok"}, {3'b0, ok4}, {3'b0, v.ok});
            chk({v.name, "_err"}, {3'b0, err4}, {3'b0, v.err});
            chk({v.name, "_type"}, {2'b0, type4}, {2'b0, v.typ});
            en4 = 1'b0;
        end else begin
            en4 = 1'b0;
            @(negedge clk);
            chk({v.name, "_ok"}, {3'b0, ok4}, {3'b0, v.ok});
            chk({v.name, "_err"}, {3'b0, err4}, {3'b0, v.err});
            chk({v.name, "_type"}, {2'b0, type4}, {2'b0, v.typ});
        end
        @(negedge clk);
        chk({v.name, "_pulse_end"}, {2'b0, ok4, err4}, 4'h0);
        chk({v.name, "_type_held"}, {2'b0, type4}, {2'b0, v.typ});
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0;
        en4 = 1'b0; da4 = 4'h0; mac4 = 48'h0; promisc4 = 1'b0; bc_en4 = 1'b0; mc_en4 = 1'b0;
        en8 = 1'b0; da8 = 8'h0; mac8 = 48'h001122334455; promisc8 = 1'b0; bc_en8 = 1'b0; mc_en8 = 1'b0;

        vecs[0] = '{"uc_hit",      48'h123456789ABC, 48'h123456789ABC, 1'b0, 1'b0, 1'b0, 12, 1'b1, 1'b0, 2'b00};
        vecs[1] = '{"uc_miss",     48'h123406789ABC, 48'h123456789ABC, 1'b0, 1'b0, 1'b0, 12, 1'b0, 1'b1, 2'b00};
        vecs[2] = '{"uc_promisc",  48'h123406789ABC, 48'h123456789ABC, 1'b1, 1'b0, 1'b0, 12, 1'b1, 1'b0, 2'b00};
        vecs[3] = '{"bc_off",      48'hFFFFFFFFFFFF, 48'h123456789ABC, 1'b0, 1'b0, 1'b0, 12, 1'b0, 1'b1, 2'b10};
        vecs[4] = '{"bc_on",       48'hFFFFFFFFFFFF, 48'h123456789ABC, 1'b0, 1'b1, 1'b0, 12, 1'b1, 1'b0, 2'b10};
        vecs[5] = '{"mc_on",       48'h01005E000001, 48'h123456789ABC, 1'b0, 1'b0, 1'b1, 12, 1'b1, 1'b0, 2'b01};
        vecs[6] = '{"mc_off",      48'h01005E000001, 48'h123456789ABC, 1'b0, 1'b1, 1'b0, 12, 1'b0, 1'b1, 2'b01};
        vecs[7] = '{"mc_promisc",  48'h01005E000001, 48'h123456789ABC, 1'b1, 1'b0, 1'b0, 12, 1'b1, 1'b0, 2'b01};
        vecs[8] = '{"trunc",       48'h123456789ABC, 48'h123456789ABC, 1'b1, 1'b1, 1'b1, 7,  1'b0, 1'b1, 2'b11};
        vecs[9] = '{"bc_promisc",  48'hFFFFFFFFFFFF, 48'h123456789ABC, 1'b1, 1'b0, 1'b0, 12, 1'b1, 1'b0, 2'b10};

        repeat (2) @(negedge clk);
        chk("rst_out4", {ok4, err4, type4}, 4'h0);
        chk("rst_busy4", {3'b0, busy4}, 4'h0);
        chk("rst_out8", {ok8, err8, type8}, 4'h0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            run_vec(vecs[v]);
        end

        // Byte mode: decision after beat 5, then 20 overlong beats produce nothing.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en8 = 1'b1;
            da8 = 8'h11 * 8'(i);
        end
        @(negedge clk);
        chk("b8_ok", {3'b0, ok8}, 4'h1);
        chk("b8_err", {3'b0, err8}, 4'h0);
        chk("b8_type", {2'b0, type8}, 4'h0);
        for (int i = 0; i < 20; i++) begin
            da8 = 8'hA0 + 8'(i);
            @(negedge clk);
            chk("b8_overlong", {1'b0, ok8, err8, busy8}, 4'h0);
        end
        en8 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en8 = 1'b1;
            da8 = 8'h11 * 8'(i);
        end
        @(negedge clk);
        chk("b8_second_ok", {3'b0, ok8}, 4'h1);
        chk("b8_second_type", {2'b0, type8}, 4'h0);
        en8 = 1'b0;
        @(negedge clk);
        chk("b8_second_end", {2'b0, ok8, err8}, 4'h0);

        // Reset in the middle of a nibble-mode frame.
        mac4 = 48'h123456789ABC; promisc4 = 1'b1; bc_en4 = 1'b0; mc_en4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en4 = 1'b1;
            da4 = nib(48'h123456789ABC, i);
        end
        chk("mid_busy", {3'b0, busy4}, 4'h1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out", {ok4, err4, type4}, 4'h0);
        chk("mid_rst_busy", {3'b0, busy4}, 4'h0);
        @(negedge clk);
        en4 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_no_decision", {1'b0, ok4, err4, busy4}, 4'h0);
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rx_da_filter.md
Name: rx_da_filter

Overview:
Parametrised successor to the MAC receive destination-address checker. It sits after preamble/SFD stripping in the MAC_rx path. It consumes the 48-bit destination address as a stream of DW-bit beats gated by I_en_ck, and classifies the address as unicast, multicast or broadcast. It issues a one-cycle accept or reject decision using a runtime station address and mode controls; a decision is also made when the address is cut short.

Parameters:
DW, 4, input beat width; legal values 4 (MII nibble) or 8 (GMII byte)
BEATS, 48/DW, beats per destination address (derived, do not override)
CW, 4, beat counter width; must satisfy 2^CW > BEATS

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
I_en_ck  input  1  beat valid; high for contiguous DA beats of one frame, low between frames
I_da_hf  input  DW  DA beat data, valid when I_en_ck=1
I_mac_addr  input  48  station address, first transmitted octet in [47:40]
I_promisc  input  1  promiscuous mode: accept any complete DA
I_bc_en  input  1  accept broadcast FF-FF-FF-FF-FF-FF
I_mc_en  input  1  accept any multicast (I/G bit set, non-broadcast)
O_da_ok  output  1  one-cycle pulse: DA accepted
O_da_err  output  1  one-cycle pulse: DA rejected or truncated
O_da_type  output  2  00 unicast, 01 multicast, 10 broadcast, 11 truncated; valid while O_da_ok or O_da_err is high, held until the next decision
O_busy  output  1  high while in CMP state

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, match flags cleared; O_da_ok=0, O_da_err=0, O_da_type=00, O_busy=0.
- Beat order: octets in transmission order, octet 0 = I_mac_addr[47:40].
  - DW=4: low nibble first. Beat 2k = octet k[3:0], beat 2k+1 = octet k[7:4].
  - DW=8: beat k = octet k.
- I/G (multicast) bit = bit0 of beat 0.
- State IDLE:
  - On I_en_ck=1: latch I_promisc, I_bc_en, I_mc_en and I_mac_addr for the whole frame.
  - Evaluate beat 0, set counter=1 and go to CMP.
  - BEATS=1 is impossible; BEATS is at least 6.
- State CMP, each I_en_ck=1 cycle:
  - uc_match &= (beat == expected address slice).
  - bc_match &= (beat == all ones).
  - counter increments.
  - On the beat with counter==BEATS-1, the decision is registered on that same edge and the output pulse is visible the next cycle. Latency: 1 clock after the last beat. Then go to DONE.
- Decision priority on a complete DA:
  - bc_match: type 10; ok if I_bc_en or I_promisc, else err.
  - Else I/G=1: type 01; ok if I_mc_en or I_promisc, else err.
  - Else: type 00; ok if uc_match or I_promisc, else err.
- State CMP with I_en_ck=0 before the last beat (truncated DA):
  - O_da_err pulse, O_da_type=11, go to IDLE.
  - Promiscuous mode does not override this.
- State DONE:
  - Ignore all further beats; no outputs are generated.
  - Return to IDLE on the first cycle with I_en_ck=0.
  - A frame held high indefinitely produces exactly one decision.
- O_da_ok and O_da_err are never high in the same cycle. Each is high for exactly one cycle per frame.
- Config inputs changing mid-frame have no effect until the next IDLE→CMP transition.
- Reset asserted mid-frame: immediate return to IDLE with outputs cleared; no decision is emitted for that frame.
- Back-to-back frames with a single I_en_ck=0 gap cycle must both be decided.
- O_busy = (state==CMP).

Test Plan:
- Unicast hit: DW=4, I_mac_addr=48'h123456789ABC, beats 2,1,4,3,6,5,8,7,A,9,C,B, modes 0 -> O_da_ok pulse 1 cycle after beat 11, O_da_type=00.
- Unicast miss plus promiscuous: same stream with beat 5 = 4'h0 -> O_da_err, type 00; repeat with I_promisc=1 -> O_da_ok, type 00.
- Broadcast/multicast: DA FF:FF:FF:FF:FF:FF with I_bc_en=0 -> O_da_err, type 10; with I_bc_en=1 -> O_da_ok, type 10. DA 01:00:5E:00:00:01 with I_mc_en=1 -> O_da_ok, type 01.
- Truncation: I_en_ck drops after 7 beats -> O_da_err the following cycle, type 11, even with I_promisc=1.
- Byte mode and overlong frame: DW=8, I_mac_addr=48'h0011223344 55, beats 00,11,22,33,44,55 -> O_da_ok after beat 5; I_en_ck held for 20 further beats -> no additional pulses; one-cycle gap then a second matching DA -> second O_da_ok.
- Reset mid-frame: rst low at beat 4 -> outputs 0 and O_busy=0 immediately; after release, a full frame is decided normally.
